// File: rtl/usr_seq_ctrl_pkg.sv
// Shared constants for the usr sequencer: usr mode encodings and controller FSM states.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    CAPT  = 2'b11
  } state_t;

  function automatic logic [1:0] shift_mode(input logic dir);
    return dir ? MODE_SHL : MODE_SHR;
  endfunction

endpackage

// File: rtl/usr_seq_ctrl_if.sv
// Command handshake between a requester and usr_seq_ctrl.
// cmd_rot exists only when USR_ROTATE_EN is defined.
interface usr_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_fill;
`ifdef USR_ROTATE_EN
  logic             cmd_rot;
`endif

  modport master (
    output cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_fill,
`ifdef USR_ROTATE_EN
    output cmd_rot,
`endif
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_fill,
`ifdef USR_ROTATE_EN
    input  cmd_rot,
`endif
    output cmd_ready
  );
endinterface

// File: rtl/usr_seq_ctrl.sv
// Sequences one usr instance through load, N shifts and capture per accepted command.
// Optional USR_ROTATE_EN: per-command recirculation of usr_q into the serial input.
module usr_seq_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  usr_seq_ctrl_if.slave    cmd,
  output logic [1:0]       usr_mode,
  output logic [WIDTH-1:0] usr_par_in,
  output logic             usr_s_left,
  output logic             usr_s_right,
  input  logic [WIDTH-1:0] usr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic [CNT_W-1:0] count_q;
  logic             fill_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             rot_q;
  logic             accept;

  assign accept = (state_q == IDLE) && cmd.cmd_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cmd.cmd_valid) state_d = LOAD;
      LOAD:  state_d = (count_q == '0) ? CAPT : SHIFT;
      SHIFT: if (cnt_q == CNT_W'(1)) state_d = CAPT;
      CAPT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      dir_q    <= 1'b0;
      count_q  <= '0;
      fill_q   <= 1'b0;
      rot_q    <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        data_q  <= cmd.cmd_data;
        dir_q   <= cmd.cmd_dir;
        count_q <= cmd.cmd_count;
        fill_q  <= cmd.cmd_fill;
`ifdef USR_ROTATE_EN
        rot_q   <= cmd.cmd_rot;
`else
        rot_q   <= 1'b0;
`endif
      end
      if (state_q == LOAD)       cnt_q <= count_q;
      else if (state_q == SHIFT) cnt_q <= cnt_q - CNT_W'(1);
      done_q <= (state_q == CAPT);
      if (state_q == CAPT) result_q <= usr_q;
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    usr_mode      = MODE_HOLD;
    usr_par_in    = '0;
    usr_s_left    = fill_q;
    usr_s_right   = fill_q;
    busy          = (state_q != IDLE);
    cmd.cmd_ready = (state_q == IDLE);
    unique case (state_q)
      LOAD: begin
        usr_mode   = MODE_LOAD;
        usr_par_in = data_q;
      end
      SHIFT: begin
        usr_mode = shift_mode(dir_q);
        // Recirculation is combinational from usr_q; only the active side matters.
        if (rot_q) begin
          usr_s_right = usr_q[0];
          usr_s_left  = usr_q[WIDTH-1];
        end
      end
      default: ;
    endcase
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Directed bench for usr_seq_ctrl driving a behavioural usr with hand-computed results.
module tb_usr_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       usr_mode;
  logic [WIDTH-1:0] usr_par_in;
  logic             usr_s_left, usr_s_right;
  logic [WIDTH-1:0] usr_q;
  logic             busy, done;
  logic [WIDTH-1:0] result;

  int total = 0;
  int bad   = 0;

  usr_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

  usr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_if),
    .usr_mode    (usr_mode),
    .usr_par_in  (usr_par_in),
    .usr_s_left  (usr_s_left),
    .usr_s_right (usr_s_right),
    .usr_q       (usr_q),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  always #5 clk = ~clk;

  // Behavioural universal shift register.
  initial usr_q = '0;
  always @(posedge clk) begin
    case (usr_mode)
      2'b01:   usr_q <= {usr_s_right, usr_q[WIDTH-1:1]};
      2'b10:   usr_q <= {usr_q[WIDTH-2:0], usr_s_left};
      2'b11:   usr_q <= usr_par_in;
      default: usr_q <= usr_q;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] data, input logic dir, input logic [2:0] count,
                       input logic fill, input logic rot);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_data  = data;
    cmd_if.cmd_dir   = dir;
    cmd_if.cmd_count = count;
    cmd_if.cmd_fill  = fill;
`ifdef USR_ROTATE_EN
    cmd_if.cmd_rot   = rot;
`else
    if (rot) $display("note: rot ignored without USR_ROTATE_EN");
`endif
  endtask

  // Called at the negedge before the accept edge with cmd_valid high.
  // If hold is set, a follow-on command is presented during the sequence.
  task automatic follow(input string tag, input logic [3:0] data, input logic dir,
                        input int count, input logic fill, input logic rot,
                        input logic [3:0] exp_res, input logic hold,
                        input logic [3:0] nd, input logic ndir, input logic [2:0] ncnt);
    logic [1:0] exp_mode;
    check({tag, "_ready"}, cmd_if.cmd_ready, 1);
    for (int k = 1; k <= count + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) issue(nd, ndir, ncnt, 1'b0, 1'b0);
        else      cmd_if.cmd_valid = 1'b0;
        check({tag, "_par_in"}, usr_par_in, data);
        if (!rot) check({tag, "_s_right"}, usr_s_right, fill);
      end
      exp_mode = (k == 1) ? 2'b11 : (k <= count + 1) ? (dir ? 2'b10 : 2'b01) : 2'b00;
      check($sformatf("%s_mode%0d", tag, k), usr_mode, exp_mode);
      check($sformatf("%s_busy%0d", tag, k), busy, 1);
      check($sformatf("%s_rdy%0d", tag, k), cmd_if.cmd_ready, 0);
      check($sformatf("%s_done%0d", tag, k), done, 0);
    end
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_done_ready"}, cmd_if.cmd_ready, 1);
    check({tag, "_done_busy"}, busy, 0);
    check({tag, "_done_mode"}, usr_mode, 2'b00);
    if (!hold) begin
      @(negedge clk);
      check({tag, "_done_drop"}, done, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = '0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_count = '0;
    cmd_if.cmd_fill  = 1'b0;
`ifdef USR_ROTATE_EN
    cmd_if.cmd_rot   = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("rst_mode", usr_mode, 2'b00);
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 4'b0000);
    check("rst_par_in", usr_par_in, 4'b0000);
    check("rst_serial", {usr_s_left, usr_s_right}, 2'b00);
    rst = 1'b0;

    // Reset during the second SHIFT cycle of a count=3 command aborts it.
    @(negedge clk);
    issue(4'b0101, 1'b0, 3'd3, 1'b1, 1'b0);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    check("abort_load", usr_mode, 2'b11);
    @(negedge clk);
    check("abort_shift1", usr_mode, 2'b01);
    @(negedge clk);
    check("abort_shift2", usr_mode, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_mode", usr_mode, 2'b00);
    check("abort_ready", cmd_if.cmd_ready, 1);
    check("abort_done", done, 0);
    check("abort_result", result, 4'b0000);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end

    issue(4'b1010, 1'b0, 3'd1, 1'b1, 1'b0);
    follow("shr1", 4'b1010, 1'b0, 1, 1'b1, 1'b0, 4'b1101, 1'b0, 4'b0, 1'b0, 3'd0);

    // Second command held during the first; accepted on the done cycle.
    issue(4'b1010, 1'b1, 3'd2, 1'b0, 1'b0);
    follow("shl2", 4'b1010, 1'b1, 2, 1'b0, 1'b0, 4'b1000, 1'b1, 4'b0110, 1'b0, 3'd1);
    follow("b2b", 4'b0110, 1'b0, 1, 1'b0, 1'b0, 4'b0011, 1'b0, 4'b0, 1'b0, 3'd0);

    issue(4'b1100, 1'b0, 3'd0, 1'b1, 1'b0);
    follow("cnt0", 4'b1100, 1'b0, 0, 1'b1, 1'b0, 4'b1100, 1'b0, 4'b0, 1'b0, 3'd0);

    // Count larger than WIDTH floods the register with fill.
    issue(4'b0000, 1'b1, 3'd7, 1'b1, 1'b0);
    follow("cnt7", 4'b0000, 1'b1, 7, 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0, 1'b0, 3'd0);

`ifdef USR_ROTATE_EN
    issue(4'b1001, 1'b0, 3'd1, 1'b0, 1'b1);
    follow("rotr", 4'b1001, 1'b0, 1, 1'b0, 1'b1, 4'b1100, 1'b0, 4'b0, 1'b0, 3'd0);
    issue(4'b1001, 1'b1, 3'd1, 1'b0, 1'b1);
    follow("rotl", 4'b1001, 1'b1, 1, 1'b0, 1'b1, 4'b0011, 1'b0, 4'b0, 1'b0, 3'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
